// File: rtl/csc_frame_ctrl.sv
// Frame sequencer for the YUV->RGB conversion path: source read addressing on input DE,
// destination write addressing on converter DE, drain/timeout handling and sticky framing errors.
module csc_frame_ctrl #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned ADDR_W    = 20,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned DRAIN_TMO = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              clr_err_i,
  input  logic              vs_i,
  input  logic              de_i,
  input  logic              conv_de_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o,
  output logic              err_ovr_o,
  output logic              err_short_o,
  output logic              err_tmo_o
);

  localparam int unsigned CW       = ADDR_W + 1;
  localparam logic [CW-1:0] TOTAL_C = CW'(H_ACTIVE * V_ACTIVE);
  localparam int unsigned DW       = $clog2(DRAIN_TMO + 1);
  localparam logic [DW-1:0] TMO_LAST = DW'(DRAIN_TMO - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state, nxt;
  logic          vs_q, vs_edge, in_frame;
  logic [CW-1:0] rd_cnt, wr_cnt, rd_nxt, wr_nxt;
  logic [DW-1:0] drn_cnt;
  logic          set_ovr, set_short, set_tmo, clr_cnt;

  assign rd_addr_o = rd_cnt[ADDR_W-1:0];
  assign wr_addr_o = wr_cnt[ADDR_W-1:0];

  always_comb begin
    vs_edge   = (vs_i == VS_POL) && (vs_q != VS_POL);
    in_frame  = (state == S_ACTIVE) || (state == S_DRAIN);
    rd_en_o   = de_i && (state == S_ACTIVE) && (rd_cnt < TOTAL_C);
    wr_en_o   = conv_de_i && in_frame && (wr_cnt < TOTAL_C);
    rd_nxt    = rd_cnt + CW'(rd_en_o);
    wr_nxt    = wr_cnt + CW'(wr_en_o);
    set_ovr   = de_i && in_frame && (rd_cnt == TOTAL_C);
    set_short = vs_edge && in_frame;
    set_tmo   = 1'b0;
    clr_cnt   = 1'b0;
    nxt       = state;
    // Transitions look at the post-increment counts so DONE follows the last write directly.
    case (state)
      S_IDLE:   if (enable_i) nxt = S_WAIT;
      S_WAIT: begin
        if (!enable_i) nxt = S_IDLE;
        else if (vs_edge) begin
          nxt     = S_ACTIVE;
          clr_cnt = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (set_short) clr_cnt = 1'b1;
        else if (rd_nxt == TOTAL_C) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (set_short) begin
          nxt     = S_ACTIVE;
          clr_cnt = 1'b1;
        end else if (wr_nxt == TOTAL_C) nxt = S_DONE;
        // drn_cnt counts DRAIN cycles already spent, so TMO_LAST ends the DRAIN_TMO-th one.
        else if (drn_cnt == TMO_LAST) begin
          nxt     = S_DONE;
          set_tmo = 1'b1;
        end
      end
      S_DONE:   nxt = enable_i ? S_WAIT : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      // Held at the active level so a sync pulse straddling reset release is not taken as an edge.
      vs_q         <= VS_POL;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      drn_cnt      <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      err_ovr_o    <= 1'b0;
      err_short_o  <= 1'b0;
      err_tmo_o    <= 1'b0;
    end else begin
      state        <= nxt;
      vs_q         <= vs_i;
      rd_cnt       <= clr_cnt ? '0 : rd_nxt;
      wr_cnt       <= clr_cnt ? '0 : wr_nxt;
      drn_cnt      <= (state == S_DRAIN) ? drn_cnt + DW'(1) : '0;
      busy_o       <= (nxt == S_ACTIVE) || (nxt == S_DRAIN);
      frame_done_o <= (nxt == S_DONE);
      if (nxt == S_DONE) frame_cnt_o <= frame_cnt_o + 16'd1;
      err_ovr_o    <= set_ovr   | (err_ovr_o   & ~clr_err_i);
      err_short_o  <= set_short | (err_short_o & ~clr_err_i);
      err_tmo_o    <= set_tmo   | (err_tmo_o   & ~clr_err_i);
    end
  end

endmodule

// File: tb/tb_csc_frame_ctrl.sv
// Scoreboard bench for csc_frame_ctrl: stimulus pushes expected read/write addresses and
// frame-done events; a negedge monitor pops and compares whenever the DUT strobes.
module tb_csc_frame_ctrl;

  localparam int unsigned H   = 4;
  localparam int unsigned V   = 2;
  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, enable = 1'b0, clr_err = 1'b0;
  logic          vs = 1'b0, de = 1'b0, conv_de = 1'b0;
  logic          rd_en, wr_en, busy, frame_done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0]   frame_cnt;
  logic          err_ovr, err_short, err_tmo;

  always #5 clk = ~clk;

  csc_frame_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .VS_POL(1'b1), .DRAIN_TMO(TMO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clr_err_i(clr_err),
    .vs_i(vs), .de_i(de), .conv_de_i(conv_de),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .busy_o(busy), .frame_done_o(frame_done), .frame_cnt_o(frame_cnt),
    .err_ovr_o(err_ovr), .err_short_o(err_short), .err_tmo_o(err_tmo)
  );

  typedef struct {
    int cnt;
    int gap;
  } done_t;

  int    n_pass = 0;
  int    n_total = 0;
  int    rd_q[$];
  int    wr_q[$];
  done_t done_q[$];
  int    cyc = 0;
  int    last_wr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic unexpected(input string name, input longint act);
    n_total++;
    $display("FAIL %s: strobe with no queued expectation (value %0d)", name, act);
  endtask

  // Monitor: every strobe must match the head of its queue.
  initial begin
    int    exp;
    done_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en) begin
        if (rd_q.size() == 0) unexpected("rd_unexpected", rd_addr);
        else begin
          exp = rd_q.pop_front();
          check("rd_addr", rd_addr, exp);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) unexpected("wr_unexpected", wr_addr);
        else begin
          exp = wr_q.pop_front();
          check("wr_addr", wr_addr, exp);
        end
        last_wr = cyc;
      end
      if (frame_done) begin
        if (done_q.size() == 0) unexpected("done_unexpected", frame_cnt);
        else begin
          e = done_q.pop_front();
          check("done_frame_cnt", frame_cnt, e.cnt);
          check("done_latency", cyc - last_wr, e.gap);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input int n);
    for (int i = 0; i < n; i++) rd_q.push_back(i);
  endtask

  task automatic push_wr(input int n);
    for (int i = 0; i < n; i++) wr_q.push_back(i);
  endtask

  task automatic push_done(input int cnt, input int gap);
    done_t e;
    e.cnt = cnt;
    e.gap = gap;
    done_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("reset_strobes", {rd_en, wr_en, busy, frame_done}, 0);
    check("reset_errors", {err_ovr, err_short, err_tmo}, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_addrs", {rd_addr, wr_addr}, 0);
  endtask

  // One-cycle reset, then enable set in the first post-reset (IDLE) cycle.
  task automatic do_reset(input logic en);
    tick();
    rst_n = 1'b0; de = 1'b0; conv_de = 1'b0; vs = 1'b0; clr_err = 1'b0;
    tick();
    rst_n = 1'b1;
    enable = en;
  endtask

  // VS pulse, then contiguous DE run and converter DE run delayed by dly cycles.
  task automatic frame(input int n_de, input int n_conv, input int dly, input int cycles,
                       input int en_off_at, input int clr_at);
    tick();
    vs = 1'b1; de = 1'b0; conv_de = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      vs      = 1'b0;
      de      = (i < n_de);
      conv_de = (i >= dly) && (i < dly + n_conv);
      clr_err = (i == clr_at);
      if (i == en_off_at) enable = 1'b0;
      if (i == 2) begin
        @(negedge clk);
        check("busy_active", busy, 1);
      end
    end
    tick();
    de = 1'b0; conv_de = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    // Normal frame
    do_reset(1'b1);
    check_reset_outputs();
    push_rd(8); push_wr(8); push_done(1, 1);
    frame(8, 8, 3, 14, -1, -1);
    @(negedge clk);
    check("normal_errors", {err_ovr, err_short, err_tmo}, 0);
    check("normal_frame_cnt", frame_cnt, 1);
    check("normal_busy_after", busy, 0);

    // Overrun: ninth DE in the frame
    do_reset(1'b1);
    push_rd(8); push_wr(8); push_done(1, 1);
    frame(9, 8, 3, 14, -1, -1);
    @(negedge clk);
    check("ovr_flag", err_ovr, 1);
    check("ovr_rd_addr_held", rd_addr, 8);
    check("ovr_other_errors", {err_short, err_tmo}, 0);
    tick(); clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    @(negedge clk);
    check("ovr_cleared", err_ovr, 0);

    // Short frame: VS edge after five reads, then a full frame
    do_reset(1'b1);
    push_rd(5); push_wr(2);
    frame(5, 2, 3, 5, -1, -1);
    push_rd(8); push_wr(8); push_done(1, 1);
    frame(8, 8, 3, 14, -1, -1);
    @(negedge clk);
    check("short_flag", err_short, 1);
    check("short_frame_cnt", frame_cnt, 1);

    // Drain timeout: only six converter writes; DONE after six DRAIN cycles
    do_reset(1'b1);
    push_rd(8); push_wr(6); push_done(1, 6);
    frame(8, 6, 3, 16, -1, -1);
    @(negedge clk);
    check("tmo_flag", err_tmo, 1);
    check("tmo_frame_cnt", frame_cnt, 1);
    check("tmo_other_errors", {err_ovr, err_short}, 0);

    // Enable dropped mid-frame: frame completes, later VS ignored
    do_reset(1'b1);
    push_rd(8); push_wr(8); push_done(1, 1);
    frame(8, 8, 3, 14, 2, -1);
    @(negedge clk);
    check("en_off_busy", busy, 0);
    tick(); vs = 1'b1;
    tick(); vs = 1'b0; de = 1'b1; conv_de = 1'b1;
    repeat (3) tick();
    de = 1'b0; conv_de = 1'b0;
    @(negedge clk);
    check("en_off_vs_ignored", busy, 0);
    check("en_off_frame_cnt", frame_cnt, 1);

    // Clear coincident with an overrun: the set wins
    tick(); enable = 1'b1;
    push_rd(8); push_wr(8); push_done(2, 1);
    frame(9, 8, 3, 14, -1, 8);
    @(negedge clk);
    check("clr_vs_set", err_ovr, 1);

    // Reset during DRAIN
    do_reset(1'b1);
    push_rd(8); push_wr(8); push_done(1, 1);
    frame(8, 8, 3, 14, -1, -1);
    push_rd(8); push_wr(6);
    frame(8, 6, 3, 10, -1, -1);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    enable = 1'b0;
    do_reset(1'b0);
    check_reset_outputs();

    check("rd_queue_drained", rd_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
